// File: rtl/branch_predict_unit_if.sv
// Branch predictor bus: fetch-side prediction lookup, resolve-side update
// and the registered resolve results. The statistics counters exist only
// when BPU_STATS_EN is defined.
interface branch_predict_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] i_pred_pc;
    logic                o_pred_taken;
    logic                i_res_valid;
    logic [PC_WIDTH-1:0] i_res_pc;
    logic [5:0]          i_res_type;
    logic                i_flag_zero;
    logic                i_flag_sign;
    logic                i_flag_overflow;
    logic                i_flag_carry;
    logic                i_res_pred_taken;
    logic                i_flush;
    logic                o_res_valid;
    logic                o_res_taken;
    logic                o_res_mispredict;
    logic                o_res_illegal;
`ifdef BPU_STATS_EN
    logic [31:0]         o_stat_branches;
    logic [31:0]         o_stat_mispredicts;
`endif

    // Core / fetch side: drives lookups and resolves, observes results.
    modport master (
        output i_pred_pc, i_res_valid, i_res_pc, i_res_type,
        output i_flag_zero, i_flag_sign, i_flag_overflow, i_flag_carry,
        output i_res_pred_taken, i_flush,
        input  o_pred_taken, o_res_valid, o_res_taken, o_res_mispredict, o_res_illegal
`ifdef BPU_STATS_EN
        , input o_stat_branches, o_stat_mispredicts
`endif
    );

    // Predictor side.
    modport slave (
        input  i_pred_pc, i_res_valid, i_res_pc, i_res_type,
        input  i_flag_zero, i_flag_sign, i_flag_overflow, i_flag_carry,
        input  i_res_pred_taken, i_flush,
        output o_pred_taken, o_res_valid, o_res_taken, o_res_mispredict, o_res_illegal
`ifdef BPU_STATS_EN
        , output o_stat_branches, o_stat_mispredicts
`endif
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed
// by pc[IDX_W+1:2]. Lookup is combinational from the registered table;
// resolves update the table on the next edge and produce registered
// outcome/mispredict/illegal flags one cycle later.
// Optional feature macro: BPU_STATS_EN adds 32-bit branch and mispredict
// counters that a flush does not clear.
module branch_predict_unit #(
    parameter int PC_WIDTH = 32,
    parameter int ENTRIES  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    branch_predict_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [5:0] BR_BEQ  = 6'd0;
    localparam logic [5:0] BR_BNE  = 6'd1;
    localparam logic [5:0] BR_BGE  = 6'd2;
    localparam logic [5:0] BR_BGEU = 6'd3;
    localparam logic [5:0] BR_BLT  = 6'd4;
    localparam logic [5:0] BR_BLTU = 6'd5;
    localparam logic [5:0] BR_BAL  = 6'd6;

    localparam logic [1:0] CTR_WEAK_NT = 2'd1;

    // Branch outcome from the compare flags; unknown types resolve not-taken.
    function automatic logic branch_outcome(
        input logic [5:0] br_type,
        input logic       zero,
        input logic       sign,
        input logic       ovf,
        input logic       carry
    );
        logic taken;
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BGE:  taken = (sign == ovf);
            BR_BGEU: taken = carry;
            BR_BLT:  taken = (sign != ovf);
            BR_BLTU: taken = ~carry;
            BR_BAL:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // One saturating step of a 2-bit history counter.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        nxt = ctr;
        if (up && ctr != 2'd3) begin
            nxt = ctr + 2'd1;
        end else if (!up && ctr != 2'd0) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    logic [1:0]       table_q [ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             res_legal_p0;
    logic             res_taken_p0;
    logic             res_mispredict_p0;
    logic             vld_p1;
    logic             res_taken_p1;
    logic             res_mispredict_p1;
    logic             res_illegal_p1;
    logic             unused_pc_bits;

    // Only pc[IDX_W+1:2] selects an entry; the rest is aliased away.
    assign unused_pc_bits = ^{bus.i_pred_pc, bus.i_res_pc};

    assign pred_idx = bus.i_pred_pc[IDX_W+1:2];
    assign res_idx  = bus.i_res_pc[IDX_W+1:2];

    // ---- stage p0: decode the resolving branch ----
    assign res_legal_p0      = (bus.i_res_type <= BR_BAL);
    assign res_taken_p0      = branch_outcome(bus.i_res_type, bus.i_flag_zero,
                                              bus.i_flag_sign, bus.i_flag_overflow,
                                              bus.i_flag_carry);
    assign res_mispredict_p0 = res_taken_p0 ^ bus.i_res_pred_taken;

    // No bypass: a same-cycle update to this index shows up next cycle.
    assign bus.o_pred_taken = table_q[pred_idx][1];

    // History table: reset/flush to weak-not-taken, else step on legal resolves.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_WEAK_NT;
            end
        end else if (bus.i_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_WEAK_NT;
            end
        end else if (bus.i_res_valid && res_legal_p0) begin
            table_q[res_idx] <= ctr_step(table_q[res_idx], res_taken_p0);
        end
    end

    // ---- stage p1: registered resolve results, zero when no resolve ----
    // Result register; an illegal type still reports, with taken forced low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1            <= 1'b0;
            res_taken_p1      <= 1'b0;
            res_mispredict_p1 <= 1'b0;
            res_illegal_p1    <= 1'b0;
        end else begin
            vld_p1            <= bus.i_res_valid;
            res_taken_p1      <= bus.i_res_valid & res_taken_p0;
            res_mispredict_p1 <= bus.i_res_valid & res_mispredict_p0;
            res_illegal_p1    <= bus.i_res_valid & ~res_legal_p0;
        end
    end

    assign bus.o_res_valid      = vld_p1;
    assign bus.o_res_taken      = res_taken_p1;
    assign bus.o_res_mispredict = res_mispredict_p1;
    assign bus.o_res_illegal    = res_illegal_p1;

`ifdef BPU_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    // Statistics count legal resolves only and survive a flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else if (bus.i_res_valid && res_legal_p0) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (res_mispredict_p0) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign bus.o_stat_branches    = stat_branches_q;
    assign bus.o_stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a counter-table reference model,
// a result scoreboard (push on drive, pop one edge later) and immediate
// assertions at every comparison point.
`timescale 1ns/100ps
module tb_branch_predict_unit;
    localparam int PC_WIDTH = 32;
    localparam int ENTRIES  = 64;
    localparam int IDX_W    = 6;

    typedef struct packed {
        logic v;
        logic t;
        logic m;
        logic i;
    } res_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    branch_predict_unit_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    branch_predict_unit #(.PC_WIDTH(PC_WIDTH), .ENTRIES(ENTRIES)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    res_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_ctr[ENTRIES];
    int   exp_br = 0;
    int   exp_mp = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[IDX_W+1:2]);
    endfunction

    // Reference outcome, written as a lookup over the compare relations.
    function automatic logic ref_taken(input int typ, input logic z, input logic s,
                                       input logic v, input logic c);
        if (typ == 0) return z;
        if (typ == 1) return !z;
        if (typ == 2) return !(s ^ v);
        if (typ == 3) return c;
        if (typ == 4) return s ^ v;
        if (typ == 5) return !c;
        if (typ == 6) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ENTRIES; k++) exp_ctr[k] = 1;
        exp_br = 0;
        exp_mp = 0;
        sb_q.delete();
    endtask

    task automatic drive_idle(input logic flush);
        res_t e;
        bus.i_res_valid = 1'b0;
        bus.i_flush     = flush;
        e = '0;
        sb_q.push_back(e);
        if (flush) for (int k = 0; k < ENTRIES; k++) exp_ctr[k] = 1;
    endtask

    task automatic drive_res(input logic [31:0] pc, input int typ, input logic z,
                             input logic s, input logic v, input logic c,
                             input logic pt, input logic flush);
        res_t e;
        int   ix;
        logic legal;
        bus.i_res_valid      = 1'b1;
        bus.i_res_pc         = pc;
        bus.i_res_type       = 6'(typ);
        bus.i_flag_zero      = z;
        bus.i_flag_sign      = s;
        bus.i_flag_overflow  = v;
        bus.i_flag_carry     = c;
        bus.i_res_pred_taken = pt;
        bus.i_flush          = flush;
        legal = (typ >= 0 && typ <= 6);
        e.v = 1'b1;
        e.t = ref_taken(typ, z, s, v, c);
        e.m = (e.t != pt);
        e.i = !legal;
        sb_q.push_back(e);
        ix = idx_of(pc);
        if (legal) begin
            exp_br++;
            if (e.m) exp_mp++;
        end
        if (flush) begin
            for (int k = 0; k < ENTRIES; k++) exp_ctr[k] = 1;
        end else if (legal) begin
            if (e.t) exp_ctr[ix] = (exp_ctr[ix] == 3) ? 3 : exp_ctr[ix] + 1;
            else     exp_ctr[ix] = (exp_ctr[ix] == 0) ? 0 : exp_ctr[ix] - 1;
        end
    endtask

    task automatic tick(input string tag);
        res_t e;
        @(posedge i_clk);
        #1;
        check({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_valid"},  32'(bus.o_res_valid),      32'(e.v));
            check({tag, "_taken"},  32'(bus.o_res_taken),      32'(e.t));
            check({tag, "_misp"},   32'(bus.o_res_mispredict), 32'(e.m));
            check({tag, "_illegal"}, 32'(bus.o_res_illegal),   32'(e.i));
        end
        bus.i_res_valid = 1'b0;
        bus.i_flush     = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc);
        bus.i_pred_pc = pc;
        #1;
        check(tag, 32'(bus.o_pred_taken), 32'(exp_ctr[idx_of(pc)] >= 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pre;
        bus.i_pred_pc = 32'h100;
        bus.i_res_valid = 1'b0;
        bus.i_res_pc = '0;
        bus.i_res_type = '0;
        bus.i_flag_zero = 1'b0;
        bus.i_flag_sign = 1'b0;
        bus.i_flag_overflow = 1'b0;
        bus.i_flag_carry = 1'b0;
        bus.i_res_pred_taken = 1'b0;
        bus.i_flush = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("rst_pred",    32'(bus.o_pred_taken),     32'd0);
        check("rst_valid",   32'(bus.o_res_valid),      32'd0);
        check("rst_taken",   32'(bus.o_res_taken),      32'd0);
        check("rst_misp",    32'(bus.o_res_mispredict), 32'd0);
        check("rst_illegal", 32'(bus.o_res_illegal),    32'd0);
        #10;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("post_rst_pred", 32'(bus.o_pred_taken), 32'd0);
`ifdef BPU_STATS_EN
        check("rst_stat_br", bus.o_stat_branches,    32'd0);
        check("rst_stat_mp", bus.o_stat_mispredicts, 32'd0);
`endif

        // Three taken BEQ at 0x100: 1->2->3
        for (int k = 0; k < 3; k++) begin
            drive_res(32'h100, 0, 1, 0, 0, 0, exp_ctr[idx_of(32'h100)] >= 2, 1'b0);
            tick("beq");
            check_pred("beq_pred", 32'h100);
        end
        check("beq_pred_const", 32'(bus.o_pred_taken), 32'd1);

        // Four not-taken BNE at 0x100 predicted taken: 3->2->1->0->0
        for (int k = 0; k < 4; k++) begin
            drive_res(32'h100, 1, 1, 0, 0, 0, 1'b1, 1'b0);
            tick("bne");
            check_pred("bne_pred", 32'h100);
        end
        check("bne_sat_pred", 32'(bus.o_pred_taken), 32'd0);

        // BLT taken, BGEU not taken, illegal type leaves the table alone
        drive_res(32'h108, 4, 0, 1, 0, 0, 1'b0, 1'b0);
        tick("blt");
        check_pred("blt_pred", 32'h108);
        drive_res(32'h10C, 3, 0, 0, 0, 0, 1'b0, 1'b0);
        tick("bgeu");
        drive_res(32'h108, 7, 0, 0, 0, 0, 1'b1, 1'b0);
        tick("ill");
        check_pred("ill_pred_kept", 32'h108);
        check("ill_pred_const", 32'(bus.o_pred_taken), 32'd1);
        drive_idle(1'b0);
        tick("idle");

        // Same-cycle predict (0x204) and update (0x104) of index 1
        bus.i_pred_pc = 32'h204;
        pre = (exp_ctr[idx_of(32'h204)] >= 2);
        drive_res(32'h104, 6, 0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        check("nobypass_old", 32'(bus.o_pred_taken), 32'(pre));
        tick("nobypass");
        check("nobypass_new", 32'(bus.o_pred_taken), 32'd1);
        check_pred("alias_pred", 32'h3307);

        // Flush coincident with a taken resolve on an entry at 2
        drive_res(32'h10C, 6, 0, 0, 0, 0, 1'b0, 1'b0);
        tick("bal_a");
        drive_res(32'h10C, 6, 0, 0, 0, 0, 1'b0, 1'b0);
        tick("bal_b");
        check_pred("pre_flush_pred", 32'h10C);
        drive_res(32'h10C, 6, 0, 0, 0, 0, 1'b1, 1'b1);
        tick("flush_res");
        check_pred("flush_pred_10c", 32'h10C);
        check_pred("flush_pred_108", 32'h108);
        drive_res(32'h108, 6, 0, 0, 0, 0, 1'b0, 1'b0);
        tick("post_flush");
        check_pred("post_flush_pred", 32'h108);
`ifdef BPU_STATS_EN
        check("stat_br_a", bus.o_stat_branches,    32'(exp_br));
        check("stat_mp_a", bus.o_stat_mispredicts, 32'(exp_mp));
`endif

        // Reset mid-operation discards the pending resolve
        bus.i_pred_pc = 32'h108;
        drive_res(32'h108, 6, 0, 0, 0, 0, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        bus.i_res_valid = 1'b0;
        check("midrst_valid", 32'(bus.o_res_valid),  32'd0);
        check("midrst_pred",  32'(bus.o_pred_taken), 32'd0);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        drive_idle(1'b0);
        tick("after_rst");

        // Ten legal resolves, three mispredicted, then a flush
        for (int k = 0; k < 10; k++) begin
            drive_res(32'h200 + 32'(4 * k), 0, 1, 0, 0, 0, (k < 3) ? 1'b0 : 1'b1, 1'b0);
            tick("stat_run");
        end
        drive_idle(1'b1);
        tick("stat_flush");
        check_pred("stat_flush_pred", 32'h20C);
`ifdef BPU_STATS_EN
        check("stat_br_10", bus.o_stat_branches,    32'd10);
        check("stat_mp_3",  bus.o_stat_mispredicts, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
